// File: rtl/clk_edge_meter.sv
// clk_edge_meter: synchronises a slow clock, strobes its edges, measures period/high time, flags loss.
// Define CLK_EDGE_METER_JITTER_EN to add ClrStats and PeriodMin/PeriodMax tracking.
module clk_edge_meter #(
  parameter int CNT_W = 28,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd1000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ClkIn,
`ifdef CLK_EDGE_METER_JITTER_EN
  input  logic             ClrStats,
  output logic [CNT_W-1:0] PeriodMin,
  output logic [CNT_W-1:0] PeriodMax,
`endif
  output logic             RiseStb,
  output logic             FallStb,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] HighTime,
  output logic             Valid,
  output logic             Lost
);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, LOST} state_t;
  localparam logic [CNT_W-1:0] ONES = '1;
  state_t state_q, state_d;
  logic s1_q, s1_d, s2_q, s2_d, dly_q, dly_d;
  logic rise_stb_q, rise_stb_d, fall_stb_q, fall_stb_d;
  logic valid_q, valid_d, lost_q, lost_d;
  logic [CNT_W-1:0] per_q, per_d, high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
  logic [CNT_W-1:0] per_meas, high_meas;
  logic rise, fall, measuring, timeout;
`ifdef CLK_EDGE_METER_JITTER_EN
  logic [CNT_W-1:0] pmin_q, pmin_d, pmax_q, pmax_d;
  logic upd, first;
`endif
  always_comb begin
    rise = s2_q & ~dly_q;
    fall = ~s2_q & dly_q;
    measuring = (state_q == ARMED) || (state_q == LOCKED);
    per_meas = (per_q == ONES) ? ONES : per_q + 1'b1;
    high_meas = (high_q == ONES) ? ONES : high_q + 1'b1;
    timeout = !rise && (state_q != LOST) && (per_meas == TIMEOUT);
    s1_d = ClkIn;
    s2_d = s1_q;
    dly_d = s2_q;
    rise_stb_d = rise;
    fall_stb_d = fall;
    per_d = rise ? '0 : per_meas;
    high_d = rise ? '0 : (s2_q ? high_meas : high_q);
    high_time_d = (fall && measuring) ? high_meas : high_time_q;
    state_d = state_q;
    period_d = period_q;
    valid_d = valid_q;
    lost_d = lost_q;
    if (rise) begin
      state_d = measuring ? LOCKED : ARMED;
      lost_d = 1'b0;
      period_d = measuring ? per_meas : period_q;
      valid_d = measuring ? 1'b1 : valid_q;
    end else if (timeout) begin
      state_d = LOST;
      lost_d = 1'b1;
      valid_d = 1'b0;
    end
`ifdef CLK_EDGE_METER_JITTER_EN
    upd = rise && measuring;
    first = (state_q == ARMED) || ClrStats;
    pmin_d = upd ? ((first || per_meas < pmin_q) ? per_meas : pmin_q)
                 : ((ClrStats || timeout) ? ONES : pmin_q);
    pmax_d = upd ? ((first || per_meas > pmax_q) ? per_meas : pmax_q)
                 : ((ClrStats || timeout) ? '0 : pmax_q);
`endif
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      dly_q <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
      valid_q <= 1'b0;
      lost_q <= 1'b0;
      per_q <= '0;
      high_q <= '0;
      period_q <= '0;
      high_time_q <= '0;
`ifdef CLK_EDGE_METER_JITTER_EN
      pmin_q <= ONES;
      pmax_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      dly_q <= dly_d;
      rise_stb_q <= rise_stb_d;
      fall_stb_q <= fall_stb_d;
      valid_q <= valid_d;
      lost_q <= lost_d;
      per_q <= per_d;
      high_q <= high_d;
      period_q <= period_d;
      high_time_q <= high_time_d;
`ifdef CLK_EDGE_METER_JITTER_EN
      pmin_q <= pmin_d;
      pmax_q <= pmax_d;
`endif
    end
  end
  assign RiseStb = rise_stb_q;
  assign FallStb = fall_stb_q;
  assign Period = period_q;
  assign HighTime = high_time_q;
  assign Valid = valid_q;
  assign Lost = lost_q;
`ifdef CLK_EDGE_METER_JITTER_EN
  assign PeriodMin = pmin_q;
  assign PeriodMax = pmax_q;
`endif
endmodule

// File: tb/tb_clk_edge_meter.sv
// tb_clk_edge_meter: directed checks of edge strobes, period/high-time measurement, loss and reset.
module tb_clk_edge_meter;
  logic clk, rst, clk_in;
  logic rise_stb, fall_stb, valid, lost;
  logic [27:0] period, high_time;
  int total, bad;
`ifdef CLK_EDGE_METER_JITTER_EN
  logic clr_stats;
  logic [27:0] pmin, pmax;
`endif
  clk_edge_meter dut (
    .Clk(clk), .Rst(rst), .ClkIn(clk_in),
`ifdef CLK_EDGE_METER_JITTER_EN
    .ClrStats(clr_stats), .PeriodMin(pmin), .PeriodMax(pmax),
`endif
    .RiseStb(rise_stb), .FallStb(fall_stb), .Period(period),
    .HighTime(high_time), .Valid(valid), .Lost(lost)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; clk_in = 1'b0;
    tick(3);
    rst = 1'b0;
    total++; if ({rise_stb, fall_stb, valid, lost} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {rise_stb, fall_stb, valid, lost}); end
    total++; if (period !== 28'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
    total++; if (high_time !== 28'd0) begin bad++; $display("FAIL reset_high got=%0d exp=0", high_time); end
    tick(999);
    total++; if (lost !== 1'b0) begin bad++; $display("FAIL lost_early got=%b exp=0", lost); end
    tick(1);
    total++; if (lost !== 1'b1) begin bad++; $display("FAIL lost_1000 got=%b exp=1", lost); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL lost_valid got=%b exp=0", valid); end
  endtask
  task automatic test_lock;
    clk_in = 1'b1;
    tick(2);
    total++; if (rise_stb !== 1'b0) begin bad++; $display("FAIL stb_early got=%b exp=0", rise_stb); end
    tick(1);
    total++; if (rise_stb !== 1'b1) begin bad++; $display("FAIL stb_on got=%b exp=1", rise_stb); end
    total++; if (lost !== 1'b0) begin bad++; $display("FAIL lost_clear got=%b exp=0", lost); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL armed_valid got=%b exp=0", valid); end
    tick(1);
    total++; if (rise_stb !== 1'b0) begin bad++; $display("FAIL stb_width got=%b exp=0", rise_stb); end
    tick(21);
    clk_in = 1'b0;
    tick(3);
    total++; if (fall_stb !== 1'b1) begin bad++; $display("FAIL fall_stb got=%b exp=1", fall_stb); end
    total++; if (high_time !== 28'd25) begin bad++; $display("FAIL high50 got=%0d exp=25", high_time); end
    tick(22);
    clk_in = 1'b1;
    tick(2);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL valid_early got=%b exp=0", valid); end
    tick(1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL lock_valid got=%b exp=1", valid); end
    total++; if (period !== 28'd50) begin bad++; $display("FAIL lock_period got=%0d exp=50", period); end
    tick(22);
    clk_in = 1'b0;
    tick(25);
    clk_in = 1'b1;
    tick(25);
    clk_in = 1'b0;
    tick(25);
  endtask
  task automatic test_lost;
    tick(952);
    total++; if (lost !== 1'b0 || valid !== 1'b1) begin bad++; $display("FAIL lost_pre got=%b%b exp=01", lost, valid); end
    tick(1);
    total++; if (lost !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL lost_set got=%b%b exp=10", lost, valid); end
    total++; if (period !== 28'd50) begin bad++; $display("FAIL lost_hold got=%0d exp=50", period); end
    clk_in = 1'b1;
    tick(3);
    total++; if (lost !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL relock1 got=%b%b exp=00", lost, valid); end
    tick(22);
    clk_in = 1'b0;
    tick(25);
    clk_in = 1'b1;
    tick(3);
    total++; if (valid !== 1'b1 || period !== 28'd50) begin bad++; $display("FAIL relock2 got=%b/%0d exp=1/50", valid, period); end
    tick(22);
    clk_in = 1'b0;
    tick(25);
  endtask
  task automatic test_period_change;
    for (int i = 0; i < 60; i++) begin
      clk_in = (i % 20) < 10;
      tick(1);
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL valid_hold i=%0d got=%b exp=1", i, valid); end
    end
    total++; if (period !== 28'd20) begin bad++; $display("FAIL period20 got=%0d exp=20", period); end
    total++; if (high_time !== 28'd10) begin bad++; $display("FAIL high10 got=%0d exp=10", high_time); end
  endtask
  task automatic test_rst_mid;
    clk_in = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++; if ({rise_stb, fall_stb, valid, lost} !== 4'b0 || period !== 28'd0 || high_time !== 28'd0) begin bad++; $display("FAIL rst_mid got=%b/%0d/%0d exp=0000/0/0", {rise_stb, fall_stb, valid, lost}, period, high_time); end
    tick(3);
    total++; if (rise_stb !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL rst_rise1 got=%b%b exp=10", rise_stb, valid); end
    tick(1);
    clk_in = 1'b0;
    tick(10);
    clk_in = 1'b1;
    tick(2);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid_early got=%b exp=0", valid); end
    tick(1);
    total++; if (valid !== 1'b1 || period !== 28'd14) begin bad++; $display("FAIL rst_relock got=%b/%0d exp=1/14", valid, period); end
  endtask
`ifdef CLK_EDGE_METER_JITTER_EN
  task automatic gap(input int n);
    clk_in = 1'b1;
    tick(n / 2);
    clk_in = 1'b0;
    tick(n - n / 2);
  endtask
  task automatic test_jitter;
    rst = 1'b1; clk_in = 1'b0;
    tick(2);
    rst = 1'b0;
    total++; if (pmin !== 28'hfffffff || pmax !== 28'd0) begin bad++; $display("FAIL jit_reset got=%0d/%0d exp=268435455/0", pmin, pmax); end
    gap(50); gap(50); gap(48); gap(53); gap(50);
    clk_in = 1'b1;
    tick(3);
    total++; if (pmin !== 28'd48 || pmax !== 28'd53) begin bad++; $display("FAIL jit_minmax got=%0d/%0d exp=48/53", pmin, pmax); end
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    total++; if (pmin !== 28'hfffffff || pmax !== 28'd0) begin bad++; $display("FAIL jit_clr got=%0d/%0d exp=268435455/0", pmin, pmax); end
    tick(21);
    clk_in = 1'b0;
    tick(25);
    clk_in = 1'b1;
    tick(3);
    total++; if (pmin !== 28'd50 || pmax !== 28'd50) begin bad++; $display("FAIL jit_reload got=%0d/%0d exp=50/50", pmin, pmax); end
  endtask
`endif
  initial begin
    total = 0; bad = 0;
    rst = 1'b1; clk_in = 1'b0;
`ifdef CLK_EDGE_METER_JITTER_EN
    clr_stats = 1'b0;
`endif
    test_reset;
    test_lock;
    test_lost;
    test_period_change;
    test_rst_mid;
`ifdef CLK_EDGE_METER_JITTER_EN
    test_jitter;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
